// File: rtl/stat_scheduler_pkg.sv
// stat_scheduler_pkg: shared constants for the stat update scheduler.
//   - stat index encoding (upd_sel values)
//   - action index encoding (req/gnt bit positions)
//   - FSM state encoding
//   - action -> (stat, amount) lookup table
package stat_scheduler_pkg;

    // Stat indices as driven on upd_sel
    localparam logic [2:0] STAT_HUNGER    = 3'd0;
    localparam logic [2:0] STAT_HAPPINESS = 3'd1;
    localparam logic [2:0] STAT_HEALTH    = 3'd2;
    localparam logic [2:0] STAT_HYGIENE   = 3'd3;
    localparam logic [2:0] STAT_ENERGY    = 3'd4;
    localparam logic [2:0] STAT_SOCIAL    = 3'd5;

    // Action indices as bit positions in req/gnt
    localparam logic [2:0] ACT_FEED  = 3'd0;
    localparam logic [2:0] ACT_PLAY  = 3'd1;
    localparam logic [2:0] ACT_CLEAN = 3'd2;
    localparam logic [2:0] ACT_SLEEP = 3'd3;
    localparam logic [2:0] ACT_HEAL  = 3'd4;
    localparam int         NUM_ACTIONS = 5;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACT   = 2'd1;
    localparam logic [1:0] ST_DECAY = 2'd2;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] amt;
    } act_entry_t;

    // Which stat an action raises, and by how much
    function automatic act_entry_t act_lookup(input logic [2:0] act);
        act_entry_t e;
        case (act)
            ACT_FEED:  e = '{sel: STAT_HUNGER,    amt: 2'd3};
            ACT_PLAY:  e = '{sel: STAT_HAPPINESS, amt: 2'd2};
            ACT_CLEAN: e = '{sel: STAT_HYGIENE,   amt: 2'd3};
            ACT_SLEEP: e = '{sel: STAT_ENERGY,    amt: 2'd3};
            ACT_HEAL:  e = '{sel: STAT_HEALTH,    amt: 2'd2};
            default:   e = '{sel: STAT_HUNGER,    amt: 2'd0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/stat_scheduler_tick_gen.sv
// tick_gen: free-running decay tick counter.
//   Counts 0..TICK_COUNT-1 while ena=1, holds its count while ena=0.
//   Ports: clk, rst_n (async active-low), ena, tick (high during the wrap cycle).
module tick_gen #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick
);

    logic [23:0] cnt;
    logic        wrap;

    assign wrap = (cnt == TICK_COUNT - 24'd1);
    // Combinational so the pulse lines up with the wrap cycle itself
    assign tick = ena && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= wrap ? 24'd0 : cnt + 24'd1;
        end
    end

endmodule

// File: rtl/stat_scheduler.sv
// stat_scheduler: arbitrates between periodic stat decay and user actions,
// issuing one stat update at a time over a valid/ready port.
//   Ports: clk, rst_n (async active-low), ena (run enable),
//          req[4:0] (level requests: feed, play, clean, sleep, heal),
//          upd_ready (sink accepts), upd_valid/upd_sel/upd_inc/upd_amt (update),
//          gnt[4:0] (one-hot pulse on action acceptance),
//          tick (decay tick pulse), tick_ovf (sticky dropped-tick flag).
//   Handshake: an update transfers on a cycle where upd_valid && upd_ready;
//   upd_sel/upd_inc/upd_amt are stable while upd_valid is high and not yet accepted.
//   Build option: define STAT_SCHED_RR_EN for round-robin action selection;
//   otherwise selection is fixed priority with feed highest.
module stat_scheduler
    import stat_scheduler_pkg::*;
#(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [4:0] req,
    input  logic       upd_ready,
    output logic       upd_valid,
    output logic [2:0] upd_sel,
    output logic       upd_inc,
    output logic [1:0] upd_amt,
    output logic [4:0] gnt,
    output logic       tick,
    output logic       tick_ovf
);

    logic [1:0] state;
    logic       pending;
    logic [2:0] act_idx;
    logic [2:0] pick;
    logic       found;
    logic       sweep_done;
    act_entry_t pick_entry;

    tick_gen #(.TICK_COUNT(TICK_COUNT)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .tick  (tick)
    );

    assign upd_valid  = (state != ST_IDLE);
    assign gnt        = (state == ST_ACT && upd_ready) ? (5'd1 << act_idx) : 5'd0;
    assign sweep_done = (state == ST_DECAY) && upd_ready && (upd_sel == STAT_SOCIAL);
    assign pick_entry = act_lookup(pick);

`ifdef STAT_SCHED_RR_EN
    logic [2:0] ptr;
    logic [3:0] cand;

    // Search starting at the action after the last one granted
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_ACTIONS; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NUM_ACTIONS)) cand = cand - 4'(NUM_ACTIONS);
            if (!found && req[cand[2:0]]) begin
                found = 1'b1;
                pick  = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ACT_FEED;
        end else if (state == ST_ACT && upd_ready) begin
            ptr <= (act_idx == 3'(NUM_ACTIONS - 1)) ? ACT_FEED : act_idx + 3'd1;
        end
    end
`else
    // Lowest set bit wins
    always_comb begin
        pick  = '0;
        found = |req;
        for (int k = NUM_ACTIONS - 1; k >= 0; k--) begin
            if (req[k]) pick = 3'(k);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            tick_ovf <= 1'b0;
            act_idx  <= ACT_FEED;
            upd_sel  <= '0;
            upd_inc  <= 1'b0;
            upd_amt  <= '0;
        end else begin
            // A tick landing on the sweep's final acceptance starts a fresh pending
            // tick rather than being dropped.
            if (tick && pending && !sweep_done) tick_ovf <= 1'b1;
            pending <= (pending && !sweep_done) || tick;

            case (state)
                ST_IDLE: begin
                    if (ena && pending) begin
                        state   <= ST_DECAY;
                        upd_sel <= STAT_HUNGER;
                        upd_inc <= 1'b0;
                        upd_amt <= 2'd1;
                    end else if (ena && found) begin
                        state   <= ST_ACT;
                        act_idx <= pick;
                        upd_sel <= pick_entry.sel;
                        upd_inc <= 1'b1;
                        upd_amt <= pick_entry.amt;
                    end
                end
                ST_ACT: begin
                    if (upd_ready) state <= ST_IDLE;
                end
                ST_DECAY: begin
                    if (upd_ready) begin
                        if (upd_sel == STAT_SOCIAL) state <= ST_IDLE;
                        else upd_sel <= upd_sel + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_scheduler.sv
// tb_stat_scheduler: directed self-checking bench for stat_scheduler (TICK_COUNT=16).
// Cycle n starts 1 time unit after the n-th rising edge following reset release;
// inputs are driven at cycle start, outputs are sampled on the falling edge.
module tb_stat_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [4:0] req;
    logic       upd_ready;
    logic       upd_valid;
    logic [2:0] upd_sel;
    logic       upd_inc;
    logic [1:0] upd_amt;
    logic [4:0] gnt;
    logic       tick;
    logic       tick_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [5:0] exp_q[$];

    stat_scheduler #(.TICK_COUNT(24'd16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .upd_ready (upd_ready),
        .upd_valid (upd_valid),
        .upd_sel   (upd_sel),
        .upd_inc   (upd_inc),
        .upd_amt   (upd_amt),
        .gnt       (gnt),
        .tick      (tick),
        .tick_ovf  (tick_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Hold reset for two edges, release, land on cycle 0's sample point
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        smp();
    endtask

    task automatic wait_tick(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (!tick && n < 40) begin
            step();
            smp();
            n++;
        end
        check({tag, "_tick_cyc"}, cyc, exp_cyc);
    endtask

    // Expect a full decay sweep: six accepted updates sel 0..5, subtract 1, no grant
    task automatic run_sweep(input string tag, input int first_cyc);
        int first;
        first = -1;
        for (int k = 0; k < 6; k++) exp_q.push_back({3'(k), 1'b0, 2'd1});
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
            if (upd_valid && upd_ready) begin
                if (first < 0) first = cyc;
                check({tag, "_xfer"}, {26'd0, upd_sel, upd_inc, upd_amt}, {26'd0, exp_q.pop_front()});
                check({tag, "_gnt"}, gnt, 0);
            end
            if (exp_q.size() > 0) begin
                step();
                smp();
            end
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_first"}, first, first_cyc);
        exp_q.delete();
    endtask

    logic [4:0] rr_exp [3];
    logic [4:0] tbl_req [3];
    logic [2:0] tbl_sel [3];
    logic [1:0] tbl_amt [3];
    int         cnt_v;

    initial begin
        rst_n = 1'b0; ena = 1'b1; req = 5'd0; upd_ready = 1'b1;

        // Reset state
        smp();
        check("rst_valid", upd_valid, 0);
        check("rst_sel", upd_sel, 0);
        check("rst_inc", upd_inc, 0);
        check("rst_amt", upd_amt, 0);
        check("rst_gnt", gnt, 0);
        check("rst_tick", tick, 0);
        check("rst_ovf", tick_ovf, 0);

        // Tick at cycle 15, sweep follows two cycles later
        do_reset();
        wait_tick("t1", 15);
        run_sweep("t1", 17);
        step(); smp();
        check("t1_idle_after", upd_valid, 0);
        check("t1_ovf", tick_ovf, 0);

        // Single feed request
        req = 5'b00001;
        do_reset();
        step(); smp();
        check("t2_valid", upd_valid, 1);
        check("t2_sel", upd_sel, 0);
        check("t2_inc", upd_inc, 1);
        check("t2_amt", upd_amt, 3);
        check("t2_gnt", gnt, 5'b00001);
        step(); smp();
        check("t2_idle_gap", upd_valid, 0);
        check("t2_gap_gnt", gnt, 0);
        step(); smp();
        check("t2_valid_again", upd_valid, 1);
        check("t2_gnt_again", gnt, 5'b00001);

        // Two requests held: selection policy
`ifdef STAT_SCHED_RR_EN
        rr_exp = '{5'b00001, 5'b00010, 5'b00001};
`else
        rr_exp = '{5'b00001, 5'b00001, 5'b00001};
`endif
        req = 5'b00011;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            step(); smp();
            check("t3_gnt", gnt, rr_exp[j]);
            step(); smp();
        end

        // Remaining entries of the action table
        tbl_req = '{5'b00100, 5'b01000, 5'b10000};
        tbl_sel = '{3'd3, 3'd4, 3'd2};
        tbl_amt = '{2'd3, 2'd3, 2'd2};
        req = tbl_req[0];
        do_reset();
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                step(); req = tbl_req[j]; smp();
            end
            step(); smp();
            check("t4_sel", upd_sel, tbl_sel[j]);
            check("t4_amt", upd_amt, tbl_amt[j]);
            check("t4_inc", upd_inc, 1);
            check("t4_gnt", gnt, tbl_req[j]);
        end

        // Stall during decay: second tick is dropped and flagged
        req = 5'd0; upd_ready = 1'b1;
        do_reset();
        wait_tick("t5", 15);
        step(); smp();
        step(); upd_ready = 1'b0; smp();
        check("t5_sel0", {upd_valid, upd_sel}, {1'b1, 3'd0});
        check("t5_ovf_before", tick_ovf, 0);
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            if (upd_valid && upd_sel == 3'd0 && !upd_inc && upd_amt == 2'd1 && gnt == 5'd0) cnt_v++;
            if (i < 19) begin
                step(); smp();
            end
        end
        check("t5_stable", cnt_v, 20);
        check("t5_ovf", tick_ovf, 1);
        step(); upd_ready = 1'b1; smp();
        run_sweep("t5", 37);
        step(); smp();
        check("t5_idle_after", upd_valid, 0);
        check("t5_ovf_sticky", tick_ovf, 1);

        // Tick during a stalled action
        req = 5'd0; upd_ready = 1'b0;
        do_reset();
        while (cyc < 11) begin
            step(); smp();
        end
        step(); req = 5'b00010; smp();
        step(); req = 5'b00000; smp();
        check("t6_act", {upd_valid, upd_sel, upd_inc, upd_amt}, {1'b1, 3'd1, 1'b1, 2'd2});
        check("t6_gnt_stall", gnt, 0);
        step(); req = 5'b00001; smp();
        step(); req = 5'b00000; smp();
        check("t6_tick", {tick, upd_valid}, 2'b11);
        step(); upd_ready = 1'b1; smp();
        check("t6_gnt", gnt, 5'b00010);
        step(); smp();
        check("t6_idle_gap", upd_valid, 0);
        run_sweep("t6", 18);
        cnt_v = 0;
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            if (upd_valid) cnt_v++;
        end
        check("t6_dropped_req", cnt_v, 0);

        // Asynchronous reset in the middle of a sweep
        req = 5'd0; upd_ready = 1'b1;
        do_reset();
        wait_tick("t7", 15);
        while (cyc < 20) begin
            step(); smp();
        end
        check("t7_sel3", {upd_valid, upd_sel}, {1'b1, 3'd3});
        rst_n = 1'b0;
        #1;
        check("t7_rst_outs", {upd_valid, upd_sel, upd_inc, upd_amt, gnt, tick_ovf}, 0);
        do_reset();
        cnt_v = 0;
        for (int i = 0; i < 14; i++) begin
            if (upd_valid || gnt != 5'd0) cnt_v++;
            step(); smp();
        end
        check("t7_quiet", cnt_v, 0);

        // ena low freezes the counter and blocks new work
        req = 5'd0; upd_ready = 1'b1; ena = 1'b1;
        do_reset();
        while (cyc < 4) begin
            step(); smp();
        end
        step(); ena = 1'b0; req = 5'b00001; smp();
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            if (upd_valid || tick) cnt_v++;
            if (i < 19) begin
                step(); smp();
            end
        end
        check("t8_blocked", cnt_v, 0);
        step(); ena = 1'b1; smp();
        step(); req = 5'b00000; smp();
        check("t8_gnt", gnt, 5'b00001);
        wait_tick("t8", 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stat_scheduler.md
STAT_SCHEDULER -- requirements
Module: stat_scheduler

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 24'd10_000_000: clock cycles per decay tick.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  high = scheduler runs.
REQ-005 SHALL have port req  input  5  level action requests, bit0..4 = feed, play, clean, sleep, heal.
REQ-006 SHALL have port upd_ready  input  1  stats block accepts the current update.
REQ-007 SHALL have port upd_valid  output  1  update offered.
REQ-008 SHALL have port upd_sel  output  3  stat index: 0 hunger, 1 happiness, 2 health, 3 hygiene, 4 energy, 5 social.
REQ-009 SHALL have port upd_inc  output  1  1 = add, 0 = subtract.
REQ-010 SHALL have port upd_amt  output  2  magnitude, 1..3.
REQ-011 SHALL have port gnt  output  5  one-hot, one-cycle pulse on acceptance of an action update.
REQ-012 SHALL have port tick  output  1  one-cycle pulse at tick-counter wrap.
REQ-013 SHALL have port tick_ovf  output  1  sticky: a tick was dropped.

Function
REQ-014 SHALL count 0..TICK_COUNT-1 while ena=1, pulse tick on the wrap cycle, and freeze the count while ena=0.
REQ-015 SHALL set a tick-pending flag on tick; tick while already pending SHALL be dropped and set tick_ovf until reset.
REQ-016 SHALL implement FSM IDLE, ACT, DECAY.
REQ-017 IDLE: pending tick (priority over actions) -> DECAY with index 0; else any req bit and ena=1 -> ACT; else stay.
REQ-018 In DECAY, SHALL offer six updates, upd_sel 0..5 in order, upd_inc=0, upd_amt=1, advancing only on upd_valid&&upd_ready; on acceptance of index 5, clear pending, return to IDLE.
REQ-019 In ACT, SHALL offer one update: feed hunger+3, play happiness+2, clean hygiene+3, sleep energy+3, heal health+2; on acceptance pulse the matching gnt bit, return to IDLE.
REQ-020 upd_valid SHALL assert the cycle after the IDLE decision (1-cycle latency); upd_sel/upd_inc/upd_amt SHALL hold stable while upd_valid=1 and upd_ready=0.
REQ-021 Requests SHALL be sampled only in IDLE; a request dropped before sampling gets no grant; an action once in ACT completes regardless of req.
REQ-022 A tick arriving during ACT SHALL be served in DECAY immediately after the action completes.
REQ-023 ena=0 SHALL block new ACT/DECAY entry; an in-flight transfer SHALL complete.
REQ-024 Back-to-back: IDLE SHALL be re-entered for exactly one cycle between consecutive transfers.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, counter 0, pending 0, tick_ovf 0, round-robin pointer to feed, upd_valid 0, upd_sel 0, upd_inc 0, upd_amt 0, gnt 0, tick 0.
REQ-026 Reset mid-transfer SHALL abandon it with no gnt pulse.

Configuration
REQ-027 With STAT_SCHED_RR_EN defined, action selection SHALL be round-robin, pointer moving to the bit after the last granted.
REQ-028 Without STAT_SCHED_RR_EN, selection SHALL be fixed priority, bit0 (feed) highest.

Structure
REQ-029 A shared package SHALL hold the stat index constants, action index constants, FSM state encoding, and the action-to-(stat, amount) table.
REQ-030 The tick counter SHALL be a sub-module, tick_gen (parameter TICK_COUNT, outputs tick).

Verification (bench TICK_COUNT=16)
REQ-031 Reset release, upd_ready=1, req=0 -> tick at cycle 15, then six transfers sel 0..5, inc=0, amt=1, no gnt.
REQ-032 req=5'b00001 held, upd_ready=1 -> upd_valid next cycle, sel=0, inc=1, amt=3, gnt=5'b00001 that cycle.
REQ-033 req=5'b00011 held, RR_EN defined -> gnt sequence 00001, 00010, 00001; undefined -> 00001 repeated.
REQ-034 upd_ready=0 for 20 cycles during DECAY -> second tick sets tick_ovf=1; outputs stable; sweep resumes on upd_ready=1.
REQ-035 Tick during ACT with upd_ready stalled 3 cycles -> action completes with gnt, then DECAY sweep follows.
REQ-036 rst_n low during DECAY index 3 -> all outputs 0 immediately, no further updates until next tick.
